timer_multi: RTL and testbench
==============================

// Module: timer_multi
// PURPOSE
//   Parametrised multi-channel successor to the single timer feeding CPU interrupt line pInt1.
//   N_CH independent down-counters share one prescaler. Each channel runs stopped, one-shot or periodic.
//   Expiry sets a sticky per-channel irq bit until the CPU acknowledges it; an overrun flag records missed acks.
//   Sits between the CPU output ports (configuration) and the pInt1..pInt4 interrupt inputs.
// PARAMETERS
//   N_CH   4  number of timer channels (1..8)
//   CHW    2  width of cfg_ch, >= clog2(N_CH)
//   W      8  counter / reload width in bits
//   PRESC  4  clk cycles per tick (>=1); 1 = tick every cycle
// PORTS
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-low reset
//   cfg_we    in   1      config write strobe, one cycle per write
//   cfg_ch    in   CHW    channel addressed by the write
//   cfg_mode  in   2      00 stop, 01 one-shot, 10 periodic, 11 treated as stop
//   cfg_data  in   W      reload/start count
//   int_ack   in   N_CH   per-channel irq clear, level-sampled each edge
//   irq       out  N_CH   sticky expiry flags (to pIntX)
//   irq_any   out  1      OR of irq
//   ovf       out  N_CH   expiry occurred while irq already set
//   busy      out  N_CH   channel in RUN state
// BEHAVIOUR
//   - Reset (reset=0, async): presc_cnt=0, every channel IDLE, count=0, reload=0, mode=stop;
//     irq, ovf, busy and irq_any all 0 while reset is low and after release. A reset mid-count discards all state.
//   - Prescaler: presc_cnt free-runs 0..PRESC-1. tick=1 in the cycle where presc_cnt==PRESC-1, then it wraps to 0.
//     With PRESC=1, tick is constantly 1.
//   - Channel FSM:
//       IDLE -> RUN   on a write with mode 01/10 and cfg_data!=0; loads count=reload=cfg_data and latches mode.
//       RUN  -> RUN   on a tick with count>1: count decrements by 1.
//       RUN  -> expire on a tick with count==1:
//                periodic: count reloads from reload, stays in RUN.
//                one-shot: count goes to 0, returns to IDLE.
//       any  -> IDLE  on a write with mode 00/11 or cfg_data==0; count=0. irq and ovf are unchanged.
//   - A write to a RUN channel restarts it with the new data and mode.
//   - A write on the same edge as a tick: the load wins; no decrement happens on that channel that edge.
//   - Writes with cfg_ch >= N_CH are ignored. Writes never affect unaddressed channels.
//   - Expiry latency after the write edge: between (data-1)*PRESC+1 and data*PRESC clk edges,
//     depending on prescaler phase. Exactly data edges when PRESC=1.
//   - irq[i] is set on the expiry edge (registered, visible the following cycle).
//     It is cleared on an edge where int_ack[i]=1 and no expiry occurs.
//     Expiry and ack on the same edge: irq stays 1 (set wins). ovf is not set by that event.
//   - ovf[i] is set when an expiry occurs while irq[i] is already 1 and int_ack[i]=0 on that edge.
//     ovf[i] is cleared together with irq[i] by ack.
//   - busy[i]=1 exactly while the channel is in RUN. irq_any = |irq (combinational).
//   - count is W bits and never wraps below 0: a RUN channel always has count>=1.
// TESTING (PRESC=1, N_CH=4, W=8 unless noted)
//   1. Reset: hold reset=0 with random inputs -> irq=0, ovf=0, busy=0. Release, no writes for 20 cycles -> all stay 0.
//   2. One-shot: write ch0 mode 01 data 3 at edge E -> busy[0]=1; irq[0]=1 after edge E+3; busy[0]=0 after E+3;
//      ack at E+5 -> irq[0]=0 after E+5.
//   3. Periodic with overrun: write ch2 mode 10 data 2, never ack -> irq[2] set after E+2,
//      ovf[2] set after E+4, busy[2] stays 1.
//      Then pulse int_ack[2] on an edge with no expiry -> both clear.
//   4. Ack/expire collision: ch1 periodic data 2, irq[1]=1; assert int_ack[1] on the next expiry edge
//      -> irq[1] stays 1, ovf[1] stays 0.
//   5. Stop and restart: ch3 running count 5, write mode 00 -> busy[3]=0 and no irq.
//      Write mode 01 data 0 -> stays IDLE. Write cfg_ch=3 mode 01 data 1 -> irq[3] after 1 edge.
//   6. PRESC=4: write data 2 at each of the 4 prescaler phases -> expiry 5..8 edges later.
//      Assert reset=0 mid-count -> all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/timer_multi.sv
// Multi-channel interrupt timer: N_CH down-counters sharing one prescaler, each stopped,
// one-shot or periodic, raising a sticky irq per channel with overrun tracking.
module timer_multi #(
  parameter int N_CH  = 4,
  parameter int CHW   = 2,
  parameter int W     = 8,
  parameter int PRESC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [W-1:0]    cfg_data,
  input  logic [N_CH-1:0] int_ack,
  output logic [N_CH-1:0] irq,
  output logic            irq_any,
  output logic [N_CH-1:0] ovf,
  output logic [N_CH-1:0] busy
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  logic [PW-1:0]   presc_cnt_q, presc_cnt_d;
  logic            tick;
  state_e          state_q    [N_CH];
  state_e          state_d    [N_CH];
  logic [W-1:0]    count_q    [N_CH];
  logic [W-1:0]    count_d    [N_CH];
  logic [W-1:0]    reload_q   [N_CH];
  logic [W-1:0]    reload_d   [N_CH];
  logic [N_CH-1:0] periodic_q, periodic_d;
  logic [N_CH-1:0] irq_q, irq_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] expire;

  // With PRESC=1 the counter is stuck at 0, which equals PRESC-1, so tick is constant.
  always_comb begin
    tick        = (presc_cnt_q == PW'(PRESC - 1));
    presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
  end

  // Next-state logic. A write to the addressed channel takes priority over a tick.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    expire     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && cfg_ch == CHW'(i)) begin
        if ((cfg_mode == 2'b01 || cfg_mode == 2'b10) && cfg_data != '0) begin
          state_d[i]    = RUN;
          count_d[i]    = cfg_data;
          reload_d[i]   = cfg_data;
          periodic_d[i] = cfg_mode[1];
        end else begin
          state_d[i] = IDLE;
          count_d[i] = '0;
        end
      end else if (state_q[i] == RUN && tick) begin
        if (count_q[i] == W'(1)) begin
          expire[i] = 1'b1;
          if (periodic_q[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            state_d[i] = IDLE;
            count_d[i] = '0;
          end
        end else begin
          count_d[i] = count_q[i] - 1'b1;
        end
      end
    end
  end

  // Expiry beats acknowledge; an expiry onto an unacknowledged irq is an overrun.
  always_comb begin
    irq_d = irq_q;
    ovf_d = ovf_q;
    for (int i = 0; i < N_CH; i++) begin
      if (expire[i]) begin
        irq_d[i] = 1'b1;
        if (irq_q[i] && !int_ack[i]) ovf_d[i] = 1'b1;
      end else if (int_ack[i]) begin
        irq_d[i] = 1'b0;
        ovf_d[i] = 1'b0;
      end
    end
  end

  // NOTE: every storage element is reset here, so a reset mid-count leaves no stale count or reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt_q <= '0;
      periodic_q  <= '0;
      irq_q       <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      presc_cnt_q <= presc_cnt_d;
      periodic_q  <= periodic_d;
      irq_q       <= irq_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < N_CH; i++) begin
      busy[i] = (state_q[i] == RUN);
    end
  end

  assign irq     = irq_q;
  assign ovf     = ovf_q;
  assign irq_any = |irq_q;

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: inst A (PRESC=1, N_CH=4) and inst B (PRESC=4, N_CH=3).
// Expected outputs are queued per cycle when stimulus is issued; a negedge monitor compares.
module tb_timer_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_rst, a_we, a_any;
  logic [1:0] a_ch, a_mode;
  logic [7:0] a_data;
  logic [3:0] a_ack, a_irq, a_ovf, a_busy;

  logic       b_rst, b_we, b_any;
  logic [1:0] b_ch, b_mode;
  logic [7:0] b_data;
  logic [2:0] b_ack, b_irq, b_ovf, b_busy;

  timer_multi #(.N_CH(4), .CHW(2), .W(8), .PRESC(1)) u_a (
    .clk(clk), .reset(a_rst), .cfg_we(a_we), .cfg_ch(a_ch), .cfg_mode(a_mode),
    .cfg_data(a_data), .int_ack(a_ack), .irq(a_irq), .irq_any(a_any), .ovf(a_ovf), .busy(a_busy)
  );

  timer_multi #(.N_CH(3), .CHW(2), .W(8), .PRESC(4)) u_b (
    .clk(clk), .reset(b_rst), .cfg_we(b_we), .cfg_ch(b_ch), .cfg_mode(b_mode),
    .cfg_data(b_data), .int_ack(b_ack), .irq(b_irq), .irq_any(b_any), .ovf(b_ovf), .busy(b_busy)
  );

  typedef struct {
    int         cyc;
    bit         inst;
    string      name;
    logic [3:0] irq;
    logic [3:0] ovf;
    logic [3:0] busy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int c, input bit inst, input string name,
                           input logic [3:0] irq, input logic [3:0] ovf, input logic [3:0] busy);
    exp_t e;
    e.cyc  = c;
    e.inst = inst;
    e.name = name;
    e.irq  = irq;
    e.ovf  = ovf;
    e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [3:0] ai, ao, ab;
    logic       any;
    if (e.inst == 1'b0) begin
      ai = a_irq; ao = a_ovf; ab = a_busy; any = a_any;
    end else begin
      ai = {1'b0, b_irq}; ao = {1'b0, b_ovf}; ab = {1'b0, b_busy}; any = b_any;
    end
    check({e.name, ".irq"},  ai, e.irq);
    check({e.name, ".ovf"},  ao, e.ovf);
    check({e.name, ".busy"}, ab, e.busy);
    check({e.name, ".irq_any"}, {3'b000, any}, {3'b000, |e.irq});
  endtask

  // Monitor: compares every queued expectation due this cycle.
  always @(negedge clk) begin : monitor
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic a_write(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] data);
    a_we = 1'b1; a_ch = ch; a_mode = mode; a_data = data;
    @(negedge clk);
    a_we = 1'b0; a_ch = '0; a_mode = '0; a_data = '0;
  endtask

  task automatic a_ackp(input logic [3:0] m);
    a_ack = m;
    @(negedge clk);
    a_ack = '0;
  endtask

  task automatic b_write(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] data);
    b_we = 1'b1; b_ch = ch; b_mode = mode; b_data = data;
    @(negedge clk);
    b_we = 1'b0; b_ch = '0; b_mode = '0; b_data = '0;
  endtask

  task automatic b_ackp(input logic [2:0] m);
    b_ack = m;
    @(negedge clk);
    b_ack = '0;
  endtask

  int e;
  int rel;
  int lat[4] = '{8, 7, 6, 5};

  initial begin
    a_rst = 1'b0; a_we = 1'b0; a_ch = '0; a_mode = '0; a_data = '0; a_ack = '0;
    b_rst = 1'b0; b_we = 1'b0; b_ch = '0; b_mode = '0; b_data = '0; b_ack = '0;
    @(negedge clk);

    // Reset held with random inputs, then idle after release.
    repeat (6) begin
      expect_at(cyc + 1, 0, "reset_hold", 4'h0, 4'h0, 4'h0);
      a_we = 1'($urandom); a_ch = 2'($urandom); a_mode = 2'($urandom);
      a_data = 8'($urandom); a_ack = 4'($urandom);
      b_we = 1'($urandom); b_ch = 2'($urandom); b_mode = 2'($urandom);
      b_data = 8'($urandom); b_ack = 3'($urandom);
      @(negedge clk);
    end
    a_we = 1'b0; a_ch = '0; a_mode = '0; a_data = '0; a_ack = '0;
    b_we = 1'b0; b_ch = '0; b_mode = '0; b_data = '0; b_ack = '0;
    a_rst = 1'b1;
    repeat (20) begin
      expect_at(cyc + 1, 0, "idle", 4'h0, 4'h0, 4'h0);
      @(negedge clk);
    end

    // One-shot ch0, data 3.
    e = cyc + 1;
    expect_at(e,     0, "os_load",   4'h0, 4'h0, 4'h1);
    expect_at(e + 1, 0, "os_run1",   4'h0, 4'h0, 4'h1);
    expect_at(e + 2, 0, "os_run2",   4'h0, 4'h0, 4'h1);
    expect_at(e + 3, 0, "os_expire", 4'h1, 4'h0, 4'h0);
    expect_at(e + 4, 0, "os_hold",   4'h1, 4'h0, 4'h0);
    expect_at(e + 5, 0, "os_ack",    4'h0, 4'h0, 4'h0);
    a_write(2'd0, 2'b01, 8'd3);
    wait_until(e + 4);
    a_ackp(4'h1);

    // Periodic ch2, data 2, no ack until overrun, then stop.
    e = cyc + 1;
    expect_at(e,     0, "per_load",     4'h0, 4'h0, 4'h4);
    expect_at(e + 1, 0, "per_run",      4'h0, 4'h0, 4'h4);
    expect_at(e + 2, 0, "per_irq",      4'h4, 4'h0, 4'h4);
    expect_at(e + 3, 0, "per_hold",     4'h4, 4'h0, 4'h4);
    expect_at(e + 4, 0, "per_ovf",      4'h4, 4'h4, 4'h4);
    expect_at(e + 5, 0, "per_ack",      4'h0, 4'h0, 4'h4);
    expect_at(e + 6, 0, "per_reexp",    4'h4, 4'h0, 4'h4);
    expect_at(e + 7, 0, "per_stop",     4'h4, 4'h0, 4'h0);
    expect_at(e + 8, 0, "per_stop_ack", 4'h0, 4'h0, 4'h0);
    a_write(2'd2, 2'b10, 8'd2);
    wait_until(e + 4);
    a_ackp(4'h4);
    wait_until(e + 6);
    a_write(2'd2, 2'b00, 8'd0);
    a_ackp(4'h4);

    // Ack colliding with expiry on ch1: set wins, no overrun from that edge.
    e = cyc + 1;
    expect_at(e,     0, "col_load",   4'h0, 4'h0, 4'h2);
    expect_at(e + 1, 0, "col_run",    4'h0, 4'h0, 4'h2);
    expect_at(e + 2, 0, "col_irq",    4'h2, 4'h0, 4'h2);
    expect_at(e + 3, 0, "col_hold",   4'h2, 4'h0, 4'h2);
    expect_at(e + 4, 0, "col_ackexp", 4'h2, 4'h0, 4'h2);
    expect_at(e + 5, 0, "col_after",  4'h2, 4'h0, 4'h2);
    expect_at(e + 6, 0, "col_ovf",    4'h2, 4'h2, 4'h2);
    expect_at(e + 7, 0, "col_stop",   4'h2, 4'h2, 4'h0);
    expect_at(e + 8, 0, "col_clear",  4'h0, 4'h0, 4'h0);
    a_write(2'd1, 2'b10, 8'd2);
    wait_until(e + 3);
    a_ackp(4'h2);
    wait_until(e + 6);
    a_write(2'd1, 2'b00, 8'd0);
    a_ackp(4'h2);

    // Restart of a running ch0: data 5 replaced by data 2 two edges later.
    e = cyc + 1;
    expect_at(e,     0, "rst_load",  4'h0, 4'h0, 4'h1);
    expect_at(e + 1, 0, "rst_run",   4'h0, 4'h0, 4'h1);
    expect_at(e + 2, 0, "rst_reld",  4'h0, 4'h0, 4'h1);
    expect_at(e + 3, 0, "rst_run2",  4'h0, 4'h0, 4'h1);
    expect_at(e + 4, 0, "rst_exp",   4'h1, 4'h0, 4'h0);
    expect_at(e + 5, 0, "rst_hold",  4'h1, 4'h0, 4'h0);
    expect_at(e + 6, 0, "rst_ack",   4'h0, 4'h0, 4'h0);
    a_write(2'd0, 2'b01, 8'd5);
    wait_until(e + 1);
    a_write(2'd0, 2'b01, 8'd2);
    wait_until(e + 5);
    a_ackp(4'h1);

    // Stop ch3 mid-count, ignored-start writes, then data 1.
    e = cyc + 1;
    expect_at(e,      0, "stp_load",  4'h0, 4'h0, 4'h8);
    expect_at(e + 1,  0, "stp_run1",  4'h0, 4'h0, 4'h8);
    expect_at(e + 2,  0, "stp_run2",  4'h0, 4'h0, 4'h8);
    for (int k = 3; k <= 7; k++) expect_at(e + k, 0, "stp_stopped", 4'h0, 4'h0, 4'h0);
    expect_at(e + 8,  0, "stp_data0", 4'h0, 4'h0, 4'h0);
    expect_at(e + 9,  0, "stp_data0b", 4'h0, 4'h0, 4'h0);
    expect_at(e + 10, 0, "stp_mode3", 4'h0, 4'h0, 4'h0);
    expect_at(e + 11, 0, "stp_mode3b", 4'h0, 4'h0, 4'h0);
    expect_at(e + 12, 0, "stp_d1_load", 4'h0, 4'h0, 4'h8);
    expect_at(e + 13, 0, "stp_d1_exp",  4'h8, 4'h0, 4'h0);
    expect_at(e + 14, 0, "stp_d1_ack",  4'h0, 4'h0, 4'h0);
    a_write(2'd3, 2'b01, 8'd5);
    wait_until(e + 2);
    a_write(2'd3, 2'b00, 8'd5);
    wait_until(e + 7);
    a_write(2'd3, 2'b01, 8'd0);
    wait_until(e + 9);
    a_write(2'd3, 2'b11, 8'd4);
    wait_until(e + 11);
    a_write(2'd3, 2'b01, 8'd1);
    wait_until(e + 13);
    a_ackp(4'h8);

    // PRESC=4 instance: ticks land on edges rel+4k after release.
    rel = cyc;
    b_rst = 1'b1;
    for (int p = 0; p < 4; p++) begin
      e = rel + 13 * (p + 1) + ((p - 13 * (p + 1)) % 4 + 4) % 4;
      expect_at(e,              1, $sformatf("ph%0d_load", p), 4'h0, 4'h0, 4'h1);
      expect_at(e + lat[p] - 1, 1, $sformatf("ph%0d_pre", p),  4'h0, 4'h0, 4'h1);
      expect_at(e + lat[p],     1, $sformatf("ph%0d_exp", p),  4'h1, 4'h0, 4'h0);
      expect_at(e + lat[p] + 1, 1, $sformatf("ph%0d_ack", p),  4'h0, 4'h0, 4'h0);
      wait_until(e - 1);
      b_write(2'd0, 2'b01, 8'd2);
      wait_until(e + lat[p]);
      b_ackp(3'b001);
    end

    // cfg_ch beyond N_CH is ignored.
    e = cyc + 1;
    expect_at(e,     1, "oob_write", 4'h0, 4'h0, 4'h0);
    expect_at(e + 8, 1, "oob_later", 4'h0, 4'h0, 4'h0);
    b_write(2'd3, 2'b01, 8'd1);
    wait_until(e + 8);

    // Periodic data 1 on ch1 until overrun, then asynchronous reset mid-count.
    e = cyc + 1;
    expect_at(e + 10, 1, "b_per1", 4'h2, 4'h2, 4'h2);
    b_write(2'd1, 2'b10, 8'd1);
    wait_until(e + 10);
    #2;
    b_rst = 1'b0;
    #1;
    check("async_rst.irq",  {1'b0, b_irq},  4'h0);
    check("async_rst.ovf",  {1'b0, b_ovf},  4'h0);
    check("async_rst.busy", {1'b0, b_busy}, 4'h0);
    check("async_rst.irq_any", {3'b000, b_any}, 4'h0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    while (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d left pending", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
